flofifo_mc: RTL and testbench

Multi-channel successor to the single-channel RX FIFO, intended for flocra.
- Buffers CHANNELS independent RX sample streams, each LENGTH deep, WIDTH wide.
- Merges the streams onto one output port with valid/ready handshake and a channel tag, using round-robin arbitration.
- Adds reset, flush, overflow detection and show-ahead prefetch, so the reader never needs to monitor occupancy to avoid garbage data.

---
 rtl/flofifo_mc.sv | 199 +++++++++++++++++++
 tb/tb_flofifo_mc.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flofifo_mc.sv
// flofifo_mc: multi-channel RX sample FIFO for flocra.
// CHANNELS independent LENGTH x WIDTH stream buffers feeding one show-ahead
// output port (valid/ready + channel tag) through a round-robin arbiter.
// Optional feature macro: FLOFIFO_MC_OVF_COUNT_EN adds ovf_count_o, a
// saturating 16-bit per-channel count of dropped words.
module flofifo_mc #(
  parameter int LENGTH      = 16384,
  parameter int WIDTH       = 24,
  parameter int CHANNELS    = 4,
  parameter int FULL_MARGIN = 4,
  localparam int AW = $clog2(LENGTH),
  localparam int LW = AW + 1,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CHANNELS*WIDTH-1:0] data_i,
  input  logic [CHANNELS-1:0]    valid_i,
  input  logic                   clear_i,
  output logic [WIDTH-1:0]       data_o,
  output logic [CW-1:0]          chan_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [CHANNELS*LW-1:0] locs_o,
  output logic [CHANNELS-1:0]    empty_o,
  output logic [CHANNELS-1:0]    full_o,
  output logic [CHANNELS-1:0]    overflow_o
`ifdef FLOFIFO_MC_OVF_COUNT_EN
  ,
  output logic [CHANNELS*16-1:0] ovf_count_o
`endif
);

  // Per-channel prefetch head as seen by the arbiter.
  logic [CHANNELS-1:0] head_v;
  logic [WIDTH-1:0]    head_data [CHANNELS];
  logic [CHANNELS-1:0] pop;
  logic [CHANNELS-1:0] wr_en;

  // Output stage and arbiter state.
  logic             out_v;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    out_chan;
  logic [CW-1:0]    rr_start;
  logic             can_load;
  logic             grant_v;
  logic [CW-1:0]    grant_idx;
  logic [CW-1:0]    idx;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] mem [LENGTH];
    // Pointers carry one extra bit so that equal addresses with different
    // laps mean "memory full" rather than "memory empty".
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    // a_* is the memory read register, b_* the skid; b always holds the
    // older word when both are valid, so the head is b if valid, else a.
    logic [WIDTH-1:0] a_data;
    logic [WIDTH-1:0] b_data;
    logic             a_v;
    logic             b_v;
    logic [LW-1:0]    cnt;
    logic             ovf;
    logic             issue;
    logic             pop_a;
    logic             pop_b;
    logic             a_keep;
    logic             b_keep;
    logic             acc;

    assign wr_en[c] = valid_i[c] && !full_o[c] && !clear_i;
    // Reads are issued while a prefetch slot is free; the skid absorbs the
    // read that is already in flight when the consumer stalls.
    assign issue    = (wr_ptr != rd_ptr) && !(a_v && b_v);
    assign pop_b    = pop[c] && b_v;
    assign pop_a    = pop[c] && !b_v;
    assign a_keep   = a_v && !pop_a;
    assign b_keep   = b_v && !pop_b;
    assign acc      = out_v && ready_i && (out_chan == CW'(c));

    assign head_v[c]    = a_v;
    assign head_data[c] = b_v ? b_data : a_data;

    // Sample storage and synchronous read register, with the skid move.
    // NOTE: storage and data-only registers have no reset; their contents
    // are qualified by the reset-cleared valid flags and pointers.
    always_ff @(posedge clk) begin
      if (wr_en[c]) mem[wr_ptr[AW-1:0]] <= data_i[c*WIDTH +: WIDTH];
      if (issue) begin
        a_data <= mem[rd_ptr[AW-1:0]];
        if (a_keep) b_data <= a_data;
      end
    end

    // Pointers, occupancy, sticky overflow and prefetch valid flags.
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        a_v    <= 1'b0;
        b_v    <= 1'b0;
        cnt    <= '0;
        ovf    <= 1'b0;
      end else if (clear_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        a_v    <= 1'b0;
        b_v    <= 1'b0;
        cnt    <= '0;
        ovf    <= 1'b0;
      end else begin
        if (wr_en[c]) wr_ptr <= wr_ptr + 1'b1;
        if (issue) rd_ptr <= rd_ptr + 1'b1;
        if (valid_i[c] && full_o[c]) ovf <= 1'b1;
        cnt <= cnt + LW'(wr_en[c]) - LW'(acc);
        if (issue) begin
          a_v <= 1'b1;
          b_v <= a_keep;
        end else begin
          a_v <= a_keep;
          b_v <= b_keep;
        end
      end
    end

    assign locs_o[c*LW +: LW] = cnt;
    assign empty_o[c]         = (cnt == '0);
    assign full_o[c]          = (cnt >= LW'(LENGTH - FULL_MARGIN));
    assign overflow_o[c]      = ovf;
  end

  // Round-robin search from rr_start; pops the winner when the output
  // stage is free or being drained this cycle.
  // NOTE: every variable gets a default first so no latch is inferred.
  always_comb begin
    grant_v   = 1'b0;
    grant_idx = '0;
    idx       = '0;
    pop       = '0;
    can_load  = !out_v || ready_i;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = CW'((int'(rr_start) + i) % CHANNELS);
      if (!grant_v && head_v[idx]) begin
        grant_v   = 1'b1;
        grant_idx = idx;
      end
    end
    if (can_load && grant_v) pop[grant_idx] = 1'b1;
  end

  // Single-word output stage; holds steady while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v    <= 1'b0;
      out_data <= '0;
      out_chan <= '0;
      rr_start <= '0;
    end else if (clear_i) begin
      out_v    <= 1'b0;
      out_data <= '0;
      out_chan <= '0;
      rr_start <= '0;
    end else if (can_load) begin
      out_v <= grant_v;
      if (grant_v) begin
        out_data <= head_data[grant_idx];
        out_chan <= grant_idx;
        rr_start <= (grant_idx == CW'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  assign data_o  = out_data;
  assign chan_o  = out_chan;
  assign valid_o = out_v;

`ifdef FLOFIFO_MC_OVF_COUNT_EN
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ovf
    logic [15:0] ovf_cnt;

    // Saturating count of words dropped because the channel was full.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ovf_cnt <= '0;
      end else if (clear_i) begin
        ovf_cnt <= '0;
      end else if (valid_i[c] && full_o[c] && (ovf_cnt != 16'hFFFF)) begin
        ovf_cnt <= ovf_cnt + 1'b1;
      end
    end

    assign ovf_count_o[c*16 +: 16] = ovf_cnt;
  end
`else
  // Without the counter option only the sticky overflow_o flag records drops.
`endif

endmodule

// File: tb/tb_flofifo_mc.sv
// Self-checking bench for flofifo_mc (LENGTH=16, WIDTH=24, CHANNELS=4).
// A queue-based model predicts the output port and status flags each cycle;
// directed scenarios add literal expectations.
module tb_flofifo_mc;
  localparam int L  = 16;
  localparam int W  = 24;
  localparam int CH = 4;
  localparam int M  = 4;
  localparam int LW = 5;
  localparam int CW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [CH*W-1:0] data_i;
  logic [CH-1:0]   valid_i;
  logic            clear_i;
  logic [W-1:0]    data_o;
  logic [CW-1:0]   chan_o;
  logic            valid_o;
  logic            ready_i;
  logic [CH*LW-1:0] locs_o;
  logic [CH-1:0]   empty_o;
  logic [CH-1:0]   full_o;
  logic [CH-1:0]   overflow_o;
`ifdef FLOFIFO_MC_OVF_COUNT_EN
  logic [CH*16-1:0] ovf_count_o;
`endif

  flofifo_mc #(.LENGTH(L), .WIDTH(W), .CHANNELS(CH), .FULL_MARGIN(M)) dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i),
    .clear_i(clear_i), .data_o(data_o), .chan_o(chan_o), .valid_o(valid_o),
    .ready_i(ready_i), .locs_o(locs_o), .empty_o(empty_o), .full_o(full_o),
    .overflow_o(overflow_o)
`ifdef FLOFIFO_MC_OVF_COUNT_EN
    , .ovf_count_o(ovf_count_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Words waiting in a channel (not yet in the output stage), in write order.
  typedef struct { logic [W-1:0] d; int ch; int e; } ent_t;
  ent_t         mq[$];
  int           m_locs [CH];
  bit           m_ovf  [CH];
  int           m_ovfc [CH];
  bit           m_v;
  logic [W-1:0] m_d;
  int           m_ch;
  int           m_rr;
  int           edge_n = 0;

  task automatic model_reset();
    mq.delete();
    m_v = 0; m_d = '0; m_ch = 0; m_rr = 0;
    for (int c = 0; c < CH; c++) begin
      m_locs[c] = 0; m_ovf[c] = 0; m_ovfc[c] = 0;
    end
  endtask

  function automatic int head_of(input int c);
    for (int i = 0; i < mq.size(); i++) if (mq[i].ch == c) return i;
    return -1;
  endfunction

  // A word may be granted two edges after the edge that wrote it, once it
  // is the oldest waiting word of its channel.
  task automatic model_step();
    bit acc;
    int g;
    int gi;
    int hi;
    int c2;
    acc = m_v && ready_i;
    if (clear_i) begin
      model_reset();
      return;
    end
    for (int c = 0; c < CH; c++) begin
      if (valid_i[c]) begin
        if (m_locs[c] >= L - M) begin
          m_ovf[c] = 1;
          if (m_ovfc[c] < 65535) m_ovfc[c]++;
        end else begin
          mq.push_back('{d: data_i[c*W +: W], ch: c, e: edge_n});
          m_locs[c]++;
        end
      end
    end
    if (acc) m_locs[m_ch]--;
    if (!m_v || acc) begin
      m_v = 0;
      g = -1;
      gi = -1;
      for (int k = 0; k < CH; k++) begin
        c2 = (m_rr + k) % CH;
        hi = head_of(c2);
        if (g < 0 && hi >= 0 && mq[hi].e <= edge_n - 2) begin
          g = c2;
          gi = hi;
        end
      end
      if (g >= 0) begin
        m_v = 1; m_d = mq[gi].d; m_ch = g; m_rr = (g + 1) % CH;
        mq.delete(gi);
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    edge_n++;
    if (!rst_n) model_reset();
    else model_step();
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin : cmp
    logic [CH*LW-1:0] el;
    logic [CH-1:0]    ee;
    logic [CH-1:0]    ef;
    logic [CH-1:0]    eo;
    el = '0; ee = '0; ef = '0; eo = '0;
    for (int c = 0; c < CH; c++) begin
      el[c*LW +: LW] = LW'(m_locs[c]);
      ee[c] = (m_locs[c] == 0);
      ef[c] = (m_locs[c] >= L - M);
      eo[c] = m_ovf[c];
    end
    check("cmp valid_o", valid_o, m_v);
    if (m_v) check("cmp chan/data", {chan_o, data_o}, {CW'(m_ch), m_d});
    check("cmp locs_o", locs_o, el);
    check("cmp empty_o", empty_o, ee);
    check("cmp full_o", full_o, ef);
    check("cmp overflow_o", overflow_o, eo);
`ifdef FLOFIFO_MC_OVF_COUNT_EN
    for (int c = 0; c < CH; c++)
      check("cmp ovf_count", ovf_count_o[c*16 +: 16], 16'(m_ovfc[c]));
`endif
  end

  // ---------------- output monitor ----------------
  typedef struct { int ch; logic [W-1:0] d; int cyc; } obs_t;
  obs_t outq[$];
  int   ncyc = 0;

  always @(negedge clk) begin
    ncyc++;
    if (rst_n && valid_o && ready_i)
      outq.push_back('{ch: int'(chan_o), d: data_o, cyc: ncyc});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_out(input int n, input int budget);
    for (int t = 0; t < budget && outq.size() < n; t++) tick();
    check("output count", outq.size(), n);
  endtask

  int           exp_ch [6] = '{0, 1, 0, 1, 0, 1};
  logic [W-1:0] exp_d  [6] = '{24'h10, 24'h20, 24'h11, 24'h21, 24'h12, 24'h22};
  int           bp_ch  [4] = '{0, 1, 0, 1};
  logic [W-1:0] bp_d   [4] = '{24'h100, 24'h200, 24'h101, 24'h201};
  int           nxt;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    data_i = '0; valid_i = '0; clear_i = 1'b0; ready_i = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state.
    check("reset valid_o", valid_o, 0);
    check("reset data/chan", {chan_o, data_o}, 0);
    check("reset locs_o", locs_o, 0);
    check("reset empty_o", empty_o, 4'hF);
    check("reset full/ovf", {full_o, overflow_o}, 0);

    // Latency: one word into ch2, visible three cycles later.
    ready_i = 1'b1;
    idle(5);
    data_i[2*W +: W] = 24'hABCDEF; valid_i = 4'b0100;
    tick();
    valid_i = '0;
    check("lat locs ch2 +1", locs_o[2*LW +: LW], 1);
    check("lat valid +1", valid_o, 0);
    tick();
    check("lat valid +2", valid_o, 0);
    tick();
    check("lat out +3", {valid_o, chan_o, data_o}, {1'b1, 2'd2, 24'hABCDEF});
    tick();
    check("lat locs ch2 after accept", locs_o[2*LW +: LW], 0);

    // Round-robin: 3 words each into ch0 and ch1.
    idle(2);
    outq.delete();
    for (int k = 0; k < 3; k++) begin
      data_i[0 +: W] = W'(24'h10 + k); data_i[W +: W] = W'(24'h20 + k);
      valid_i = 4'b0011;
      tick();
    end
    valid_i = '0;
    wait_out(6, 30);
    for (int i = 0; i < outq.size() && i < 6; i++) begin
      check("rr chan/data", {outq[i].ch, outq[i].d}, {exp_ch[i], exp_d[i]});
      if (i > 0) check("rr no bubble", outq[i].cyc - outq[i-1].cyc, 1);
    end

    // Backpressure: hold for 20 cycles, then drain without loss.
    idle(2);
    ready_i = 1'b0;
    outq.delete();
    data_i[0 +: W] = 24'h100; data_i[W +: W] = 24'h200; valid_i = 4'b0011;
    tick();
    data_i[0 +: W] = 24'h101; data_i[W +: W] = 24'h201;
    tick();
    valid_i = '0;
    idle(2);
    for (int t = 0; t < 20; t++) begin
      check("bp hold", {valid_o, chan_o, data_o}, {1'b1, 2'd0, 24'h100});
      tick();
    end
    ready_i = 1'b1;
    wait_out(4, 30);
    for (int i = 0; i < outq.size() && i < 4; i++)
      check("bp order", {outq[i].ch, outq[i].d}, {bp_ch[i], bp_d[i]});

    // Full/overflow: 14 writes into ch0 with the consumer stalled.
    idle(3);
    ready_i = 1'b0;
    outq.delete();
    for (int k = 0; k < 14; k++) begin
      data_i[0 +: W] = W'(24'h300 + k); valid_i = 4'b0001;
      tick();
      if (k == 10) check("full after 11", full_o[0], 0);
      if (k == 11) check("full after 12", {full_o[0], overflow_o[0], locs_o[0 +: LW]}, {1'b1, 1'b0, 5'd12});
    end
    valid_i = '0;
    check("overflow after 14", {full_o[0], overflow_o[0], locs_o[0 +: LW]}, {1'b1, 1'b1, 5'd12});
`ifdef FLOFIFO_MC_OVF_COUNT_EN
    check("ovf_count ch0", ovf_count_o[0 +: 16], 16'd2);
`endif
    ready_i = 1'b1;
    wait_out(12, 40);
    for (int i = 0; i < outq.size() && i < 12; i++)
      check("full drain order", {outq[i].ch, outq[i].d}, {32'd0, W'(24'h300 + i)});
    idle(2);
    check("full drain empty", {empty_o[0], overflow_o[0]}, 2'b11);

    // Clear with 5 queued words and a same-cycle write.
    ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      data_i[W +: W] = W'(24'h400 + k); valid_i = 4'b0010;
      tick();
    end
    valid_i = '0;
    idle(3);
    clear_i = 1'b1; data_i[2*W +: W] = 24'h500; valid_i = 4'b0100;
    tick();
    clear_i = 1'b0; valid_i = '0;
    check("clear state", {valid_o, locs_o, overflow_o, empty_o}, {1'b0, 20'd0, 4'd0, 4'hF});
    idle(2);
    check("clear write dropped", valid_o, 0);
    ready_i = 1'b1;
    data_i[0 +: W] = 24'h600; valid_i = 4'b0001;
    tick();
    valid_i = '0;
    tick();
    check("clear next +2", valid_o, 0);
    tick();
    check("clear next +3", {valid_o, chan_o, data_o}, {1'b1, 2'd0, 24'h600});

    // Wrap: 100 sequential words through ch3 with random ready.
    idle(3);
    outq.delete();
    nxt = 0;
    for (int t = 0; t < 3000 && outq.size() < 100; t++) begin
      ready_i = 1'($urandom_range(0, 1));
      if (nxt < 100 && !full_o[3]) begin
        data_i[3*W +: W] = W'(nxt); valid_i = 4'b1000; nxt++;
      end else begin
        valid_i = '0;
      end
      tick();
    end
    valid_i = '0; ready_i = 1'b1;
    check("wrap count", outq.size(), 100);
    for (int i = 0; i < outq.size() && i < 100; i++)
      check("wrap order", {outq[i].ch, outq[i].d}, {32'd3, W'(i)});
    idle(3);
    check("wrap empty ch3", empty_o[3], 1);

    // Reset mid-stream.
    for (int k = 0; k < 4; k++) begin
      data_i[W +: W] = W'(24'h700 + k); valid_i = 4'b0010;
      tick();
    end
    valid_i = '0;
    tick();
    rst_n = 1'b0;
    #2;
    check("async reset state", {valid_o, locs_o, overflow_o, empty_o}, {1'b0, 20'd0, 4'd0, 4'hF});
    @(posedge clk);
    #1 rst_n = 1'b1;
    data_i[2*W +: W] = 24'h800; valid_i = 4'b0100;
    tick();
    valid_i = '0;
    tick();
    check("reset next +2", valid_o, 0);
    tick();
    check("reset next +3", {valid_o, chan_o, data_o}, {1'b1, 2'd2, 24'h800});
    idle(2);
    check("final empty", empty_o, 4'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
